// File: rtl/fcs_mpc_sequencer_pkg.sv
// Shared definitions for the FCS-MPC switch-decision sequencer.
//   W       : width of the unsigned measurement and reference samples
//   EW      : signed working width of the prediction arithmetic (W+3)
//   state_t : sequencer FSM states
//   cost_t  : tracking-cost magnitude |i_ref - pred|
package fcs_mpc_pkg;

    localparam int W  = 8;
    localparam int EW = W + 3;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        EVAL0,
        EVAL1,
        DECIDE
    } state_t;

    typedef logic [EW-1:0] cost_t;

endpackage

// File: rtl/fcs_mpc_sequencer_if.sv
// Pad-side signal bundle of the sequencer.
//   master : drives enable, measurements and reference; observes the gate and status
//   slave  : the sequencer itself
//   en, iL, vg, vc, i_ref : enable, inductor current, source voltage, cap voltage, reference
//   u, io_oeb, busy, overrun, switch_cnt : gate, pad OE (active low), status, transition count
import fcs_mpc_pkg::*;

interface fcs_mpc_sequencer_if;

    logic          en;
    logic [W-1:0]  iL;
    logic [W-1:0]  vg;
    logic [W-1:0]  vc;
    logic [W-1:0]  i_ref;
    logic          u;
    logic          io_oeb;
    logic          busy;
    logic          overrun;
    logic [15:0]   switch_cnt;

    modport master (
        output en, iL, vg, vc, i_ref,
        input  u, io_oeb, busy, overrun, switch_cnt
    );

    modport slave (
        input  en, iL, vg, vc, i_ref,
        output u, io_oeb, busy, overrun, switch_cnt
    );

endinterface

// File: rtl/fcs_mpc_sequencer_cost_eval.sv
// Combinational one-step current prediction and tracking cost for one
// switch candidate.
//   s     : candidate switch state
//   iL, vg, vc, i_ref : captured samples (unsigned)
//   err   : |i_ref - (iL + ((s*vg - vc) >>> K_SHIFT))|
import fcs_mpc_pkg::*;

module fcs_cost_eval #(
    parameter int K_SHIFT = 2
) (
    input  logic         s,
    input  logic [W-1:0] iL,
    input  logic [W-1:0] vg,
    input  logic [W-1:0] vc,
    input  logic [W-1:0] i_ref,
    output cost_t        err
);

    logic signed [EW-1:0] il_x;
    logic signed [EW-1:0] vg_x;
    logic signed [EW-1:0] vc_x;
    logic signed [EW-1:0] ref_x;
    logic signed [EW-1:0] delta;
    logic signed [EW-1:0] pred;
    logic signed [EW-1:0] diff;

    // Three guard bits cover the full range: pred spans about -64..318 and
    // the difference to i_ref stays within +/-319 for W=8.
    assign il_x  = $signed({3'b000, iL});
    assign vg_x  = $signed({3'b000, vg});
    assign vc_x  = $signed({3'b000, vc});
    assign ref_x = $signed({3'b000, i_ref});

    assign delta = s ? (vg_x - vc_x) : (-vc_x);
    assign pred  = il_x + (delta >>> K_SHIFT);
    assign diff  = ref_x - pred;
    assign err   = diff[EW-1] ? cost_t'(-diff) : cost_t'(diff);

endmodule

// File: rtl/fcs_mpc_sequencer.sv
// Sequencing controller for the FCS-MPC gate decision of the power converter.
// Each sample period it captures iL/vg/vc/i_ref, evaluates the cost of both
// switch states through one shared cost unit, then applies the cheaper one
// to the gate subject to a minimum dwell.
//   wb_clk_i : system clock
//   wb_rst_i : synchronous active-high reset
//   bus      : measurements/enable in, gate/status out (fcs_mpc_sequencer_if.slave)
//
// state  | meaning
// IDLE   | waiting for the sample tick
// SAMPLE | registering iL, vg, vc, i_ref
// EVAL0  | cost of s=0 -> err0
// EVAL1  | cost of s=1 -> err1
// DECIDE | apply dwell rule, update u / dwell / switch count
import fcs_mpc_pkg::*;

module fcs_mpc_sequencer #(
    parameter int TS_DIV    = 16,
    parameter int K_SHIFT   = 2,
    parameter int MIN_DWELL = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    fcs_mpc_sequencer_if.slave   bus
);

    localparam logic [15:0] TS_LAST   = 16'(TS_DIV - 1);
    localparam logic [15:0] DWELL_MAX = 16'(MIN_DWELL);

    state_t        state_q;
    state_t        state_d;
    logic [15:0]   cnt_q;
    logic          tick;
    logic [W-1:0]  il_q;
    logic [W-1:0]  vg_q;
    logic [W-1:0]  vc_q;
    logic [W-1:0]  ref_q;
    cost_t         err_cur;
    cost_t         err0_q;
    cost_t         err1_q;
    logic          u_q;
    logic [15:0]   dwell_q;
    logic [15:0]   sw_cnt_q;
    logic          ovr_q;
    logic          oeb_q;
    logic          best;
    logic          do_switch;

    assign tick = bus.en && (cnt_q == TS_LAST);

    // Single cost unit, candidate selected by which evaluation state is active.
    fcs_cost_eval #(.K_SHIFT(K_SHIFT)) u_cost (
        .s     (state_q == EVAL1),
        .iL    (il_q),
        .vg    (vg_q),
        .vc    (vc_q),
        .i_ref (ref_q),
        .err   (err_cur)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = SAMPLE;
            SAMPLE:  state_d = EVAL0;
            EVAL0:   state_d = EVAL1;
            EVAL1:   state_d = DECIDE;
            DECIDE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!bus.en) state_d = IDLE;
    end

    // A tie keeps the present gate state so equal costs never cause switching.
    always_comb begin
        best = u_q;
        if (err1_q < err0_q)      best = 1'b1;
        else if (err0_q < err1_q) best = 1'b0;
        do_switch = (state_q == DECIDE) && (best != u_q) && (dwell_q >= DWELL_MAX);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q    <= '0;
            il_q     <= '0;
            vg_q     <= '0;
            vc_q     <= '0;
            ref_q    <= '0;
            err0_q   <= '0;
            err1_q   <= '0;
            u_q      <= 1'b0;
            dwell_q  <= DWELL_MAX;
            sw_cnt_q <= '0;
            ovr_q    <= 1'b0;
            oeb_q    <= 1'b1;
        end else begin
            oeb_q <= !bus.en;
            if (!bus.en) begin
                // Forced gate-off is not a decided transition: count untouched.
                cnt_q   <= '0;
                u_q     <= 1'b0;
                dwell_q <= DWELL_MAX;
            end else begin
                cnt_q <= (cnt_q == TS_LAST) ? 16'd0 : cnt_q + 16'd1;
                if (tick && (state_q != IDLE)) ovr_q <= 1'b1;
                if (state_q == SAMPLE) begin
                    il_q  <= bus.iL;
                    vg_q  <= bus.vg;
                    vc_q  <= bus.vc;
                    ref_q <= bus.i_ref;
                end
                if (state_q == EVAL0) err0_q <= err_cur;
                if (state_q == EVAL1) err1_q <= err_cur;
                if (state_q == DECIDE) begin
                    if (do_switch) begin
                        u_q     <= best;
                        dwell_q <= '0;
                        if (sw_cnt_q != 16'hFFFF) sw_cnt_q <= sw_cnt_q + 16'd1;
                    end else if (dwell_q < DWELL_MAX) begin
                        dwell_q <= dwell_q + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.u          = u_q;
    assign bus.io_oeb     = oeb_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.overrun    = ovr_q;
    assign bus.switch_cnt = sw_cnt_q;

endmodule

// File: tb/tb_fcs_mpc_sequencer.sv
// Directed bench for fcs_mpc_sequencer (TS_DIV=16, K_SHIFT=2, MIN_DWELL=2).
// Expected values are worked out by hand from the prediction formula and the
// cycle timing of the period counter and FSM.
module tb_fcs_mpc_sequencer;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    fcs_mpc_sequencer_if bus ();

    fcs_mpc_sequencer #(
        .TS_DIV    (16),
        .K_SHIFT   (2),
        .MIN_DWELL (2)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and park on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input int il, input int vg, input int vc, input int iref);
        bus.iL    = 8'(il);
        bus.vg    = 8'(vg);
        bus.vc    = 8'(vc);
        bus.i_ref = 8'(iref);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.en = 1'b0;
        set_in(0, 0, 0, 0);

        step(2);
        chk("rst_u",       32'(bus.u),          0);
        chk("rst_oeb",     32'(bus.io_oeb),     1);
        chk("rst_busy",    32'(bus.busy),       0);
        chk("rst_ovr",     32'(bus.overrun),    0);
        chk("rst_swcnt",   32'(bus.switch_cnt), 0);

        // err0=45, err1=5 -> switch to 1; dwell starts at MIN_DWELL after reset
        rst = 1'b0;
        bus.en = 1'b1;
        set_in(100, 200, 100, 120);
        step(15);
        chk("pre_tick_busy", 32'(bus.busy),   0);
        chk("en_oeb",        32'(bus.io_oeb), 0);
        step(1);
        chk("sample_busy",   32'(bus.busy), 1);
        step(3);
        chk("decide_busy",   32'(bus.busy), 1);
        chk("decide_u",      32'(bus.u),    0);
        step(1);
        chk("basic_u",       32'(bus.u),          1);
        chk("basic_busy",    32'(bus.busy),       0);
        chk("basic_swcnt",   32'(bus.switch_cnt), 1);

        // i_ref=0: err0=75, err1=125 -> best 0, held two periods by dwell
        set_in(100, 200, 100, 0);
        step(16);
        chk("dwell_n1_u",    32'(bus.u), 1);
        step(16);
        chk("dwell_n2_u",    32'(bus.u), 1);
        chk("dwell_n2_sw",   32'(bus.switch_cnt), 1);
        step(16);
        chk("dwell_n3_u",    32'(bus.u), 0);
        chk("dwell_n3_sw",   32'(bus.switch_cnt), 2);

        // back to best=1 right after a switch: dwell holds 0 twice, then 1
        set_in(100, 200, 100, 120);
        step(16);
        chk("redwell1_u",    32'(bus.u), 0);
        step(16);
        chk("redwell2_u",    32'(bus.u), 0);
        step(16);
        chk("redwell3_u",    32'(bus.u), 1);
        chk("redwell3_sw",   32'(bus.switch_cnt), 3);

        // vg=0: err0=err1=40 -> tie keeps u=1
        set_in(100, 0, 40, 50);
        step(16);
        chk("tie_u",         32'(bus.u),          1);
        chk("tie_sw",        32'(bus.switch_cnt), 3);

        // drop en while in EVAL1
        step(14);
        chk("eval1_busy",    32'(bus.busy),   1);
        chk("eval1_oeb",     32'(bus.io_oeb), 0);
        bus.en = 1'b0;
        step(1);
        chk("endrop_u",      32'(bus.u),          0);
        chk("endrop_busy",   32'(bus.busy),       0);
        chk("endrop_oeb",    32'(bus.io_oeb),     1);
        chk("endrop_sw",     32'(bus.switch_cnt), 3);
        chk("endrop_ovr",    32'(bus.overrun),    0);

        // re-enable: first tick 15 cycles later, dwell reset allows immediate switch
        set_in(100, 200, 100, 120);
        step(3);
        bus.en = 1'b1;
        step(15);
        chk("reen_pre_busy", 32'(bus.busy),   0);
        chk("reen_oeb",      32'(bus.io_oeb), 0);
        step(1);
        chk("reen_tick",     32'(bus.busy), 1);
        step(3);
        chk("reen_dec_u",    32'(bus.u), 0);
        step(1);
        chk("reen_u",        32'(bus.u),          1);
        chk("reen_sw",       32'(bus.switch_cnt), 4);

        // let dwell saturate with ties, then reset while a switch is pending in DECIDE
        set_in(100, 0, 40, 50);
        step(16);
        chk("tie2_u",        32'(bus.u), 1);
        step(16);
        chk("tie3_sw",       32'(bus.switch_cnt), 4);
        set_in(100, 200, 100, 0);
        step(15);
        chk("pre_rst_busy",  32'(bus.busy), 1);
        chk("pre_rst_u",     32'(bus.u),    1);
        rst = 1'b1;
        step(1);
        chk("midrst_u",      32'(bus.u),          0);
        chk("midrst_sw",     32'(bus.switch_cnt), 0);
        chk("midrst_busy",   32'(bus.busy),       0);
        chk("midrst_oeb",    32'(bus.io_oeb),     1);
        chk("midrst_ovr",    32'(bus.overrun),    0);
        rst = 1'b0;
        step(2);
        chk("post_rst_u",    32'(bus.u),      0);
        chk("post_rst_oeb",  32'(bus.io_oeb), 0);
        chk("post_rst_sw",   32'(bus.switch_cnt), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
